// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: accepts one request, shifts at most 7 bits per cycle, then holds the result.
// Define SHIFT_SEQ_ROR_EN to make op 11 a rotate-right; otherwise op 11 passes the operand through.
module shift_sequencer #(
  parameter int DATA_W = 8,
  parameter int AMT_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [DATA_W-1:0] in_data,
  input  logic [AMT_W-1:0]  in_amt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

`ifdef SHIFT_SEQ_ROR_EN
  localparam bit ROR_EN = 1'b1;
`else
  localparam bit ROR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [DATA_W-1:0]   acc_reg;
  logic [1:0]          op_reg;
  logic [AMT_W-1:0]    rem_reg;
  logic [2:0]          step;
  logic [AMT_W-1:0]    step_ext;
  logic [DATA_W-1:0]   shifted;
  logic [DATA_W-1:0]   rotated;
  logic                accept;
  logic                skip_shift;

  // Each SHIFT cycle consumes up to 7 bits of the remaining amount.
  assign step     = (rem_reg > AMT_W'(7)) ? 3'd7 : rem_reg[2:0];
  assign step_ext = {{(AMT_W-3){1'b0}}, step};

  assign accept     = in_valid && in_ready;
  assign skip_shift = (in_amt == '0) || (!ROR_EN && (in_op == OP_ROR));

  always_comb begin
    rotated = (acc_reg >> step) | (acc_reg << (4'd8 - {1'b0, step}));
    case (op_reg)
      OP_SLL:  shifted = acc_reg << step;
      OP_SRL:  shifted = acc_reg >> step;
      OP_SRA:  shifted = DATA_W'($signed(acc_reg) >>> step);
      default: shifted = ROR_EN ? rotated : acc_reg;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = skip_shift ? DONE : SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (rem_reg == step_ext) state_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      op_reg    <= OP_SLL;
      rem_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        acc_reg <= in_data;
        op_reg  <= in_op;
        rem_reg <= in_amt;
      end else if (state_reg == SHIFT) begin
        acc_reg <= shifted;
        rem_reg <= rem_reg - step_ext;
      end
    end
  end

  assign out_data = acc_reg;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: results, latency in edges (accept edge = 1), SHIFT cycle counts,
// backpressure, mid-shift reset and op 11 in both build configurations.
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_op;
  logic [7:0] in_data;
  logic [4:0] in_amt;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  shift_sequencer #(.DATA_W(8), .AMT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request, measure latency and SHIFT cycles, check the result, optionally drain it.
  task automatic run_txn(input string tag, input logic [1:0] op, input logic [7:0] data,
                         input logic [4:0] amt, input logic [7:0] exp_data,
                         input int exp_lat, input int exp_shifts, input bit drain);
    int edges;
    int shifts;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_op    = op;
    in_data  = data;
    in_amt   = amt;
    tick();
    in_valid = 1'b0;
    in_data  = 8'h5A;
    in_amt   = 5'd9;
    edges    = 1;
    shifts   = 0;
    while (!out_valid && edges < 40) begin
      if (busy) shifts++;
      tick();
      edges++;
    end
    check({tag, "_latency"}, 32'(edges), 32'(exp_lat));
    check({tag, "_shifts"}, 32'(shifts), 32'(exp_shifts));
    check({tag, "_data"}, 32'(out_data), 32'(exp_data));
    $display("[TB] txn %s op=%0d data=%02h amt=%0d -> out=%02h edges=%0d shifts=%0d",
             tag, op, data, amt, out_data, edges, shifts);
    if (drain) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
      check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 2'b00;
    in_data   = 8'h00;
    in_amt    = 5'd0;
    out_ready = 1'b0;
    tick();
    tick();
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_out_data", 32'(out_data), 32'h00);
    rst_n = 1'b1;
    tick();

    run_txn("sra_96_3",  2'b10, 8'h96, 5'd3,  8'hF2, 2, 1, 1'b1);
    run_txn("sll_81_0",  2'b00, 8'h81, 5'd0,  8'h81, 1, 0, 1'b1);
    run_txn("sra_80_20", 2'b10, 8'h80, 5'd20, 8'hFF, 4, 3, 1'b1);
    run_txn("srl_80_20", 2'b01, 8'h80, 5'd20, 8'h00, 4, 3, 1'b1);
    run_txn("sll_03_7",  2'b00, 8'h03, 5'd7,  8'h80, 2, 1, 1'b1);
    run_txn("srl_ff_8",  2'b01, 8'hFF, 5'd8,  8'h00, 3, 2, 1'b1);
    run_txn("sra_7f_20", 2'b10, 8'h7F, 5'd20, 8'h00, 4, 3, 1'b1);
    run_txn("sll_b5_1",  2'b00, 8'hB5, 5'd1,  8'h6A, 2, 1, 1'b1);
`ifdef SHIFT_SEQ_ROR_EN
    run_txn("ror_96_11", 2'b11, 8'h96, 5'd11, 8'hD2, 3, 2, 1'b1);
`else
    run_txn("op3_96_11", 2'b11, 8'h96, 5'd11, 8'h96, 1, 0, 1'b1);
`endif

    // Backpressure: result held for 5 cycles while a stray request is ignored.
    run_txn("srl_f0_2", 2'b01, 8'hF0, 5'd2, 8'h3C, 2, 1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 2);
      in_op    = 2'b00;
      in_data  = 8'hAA;
      in_amt   = 5'd0;
      tick();
      in_valid = 1'b0;
      check("hold_data", 32'(out_data), 32'h3C);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_out_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("release_in_ready", 32'(in_ready), 32'd1);
    check("release_busy", 32'(busy), 32'd0);
    check("release_out_valid", 32'(out_valid), 32'd0);
    $display("[TB] txn backpressure hold 5 cycles out=3c released");

    // Reset in the middle of a long SLL.
    in_valid = 1'b1;
    in_op    = 2'b00;
    in_data  = 8'h01;
    in_amt   = 5'd31;
    tick();
    in_valid = 1'b0;
    tick();
    check("midrst_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'h00);
    begin
      int pulses = 0;
      for (int i = 0; i < 8; i++) begin
        tick();
        if (out_valid) pulses++;
      end
      check("midrst_no_pulse", 32'(pulses), 32'd0);
    end
    $display("[TB] txn reset during SLL 01 amt=31 discarded");

    run_txn("post_rst_srl", 2'b01, 8'hC0, 5'd6, 8'h03, 2, 1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
